// File: rtl/capture_sequencer_pkg.sv
// Shared types for the capture sequencer: state encoding and default buffer width.
package capture_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  // Encoding is visible through the status register.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// Decoder handshake and sample-buffer write bus of the capture sequencer.
interface capture_sequencer_if
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              capture_en;
  logic              trigger_ready;
  logic              trigger_start;
  logic              sample_valid;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;

  // Sequencer side.
  modport master (
    output capture_en,
    output trigger_ready,
    output buf_we,
    output buf_addr,
    input  trigger_start,
    input  sample_valid
  );

  // Decoder / buffer side.
  modport slave (
    input  capture_en,
    input  trigger_ready,
    input  buf_we,
    input  buf_addr,
    output trigger_start,
    output sample_valid
  );

endinterface

// File: rtl/capture_sequencer.sv
// Capture run sequencer: pre-trigger fill, trigger wait, post-trigger record
// into a circular sample buffer, with readout pointers for upload.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                abort,
  input  logic                clear,
  input  logic [ADDR_W:0]     pre_len,
  input  logic [ADDR_W:0]     post_len,
  capture_sequencer_if.master bus,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   start_addr,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state
);

  localparam logic [ADDR_W-1:0] WP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  cap_state_t        st_q, st_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   pre_q, pre_d;
  logic [ADDR_W:0]   post_q, post_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              cen_q, trdy_q;
  logic              active;
  logic              we;

  // Write strobe follows sample_valid while a run is in progress; abort blocks it.
  always_comb begin
    active = (st_q == PRETRIG) || (st_q == ARMED) || (st_q == POST);
    we     = bus.sample_valid && active && !abort;
  end

  // Next-state and pointer/counter update.
  always_comb begin
    st_d    = st_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    post_d  = post_q;
    trig_d  = trig_q;
    start_d = start_q;

    if (abort) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE, DONE: begin
          if (arm) begin
            pre_d  = pre_len;
            post_d = post_len;
            wp_d   = '0;
            cnt_d  = '0;
            st_d   = (pre_len == '0) ? ARMED : PRETRIG;
          end else if (clear && (st_q == DONE)) begin
            st_d = IDLE;
          end
        end

        PRETRIG: begin
          if (we) begin
            wp_d  = wp_q + WP_ONE;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == pre_q - CNT_ONE) st_d = ARMED;
          end
        end

        ARMED: begin
          if (we) wp_d = wp_q + WP_ONE;
          if (bus.trigger_start) begin
            trig_d  = wp_q;
            // Low bits only: pre_len == DEPTH wraps to an offset of 0.
            start_d = wp_q - pre_q[ADDR_W-1:0];
            cnt_d   = (we && (post_q != '0)) ? CNT_ONE : '0;
            if (post_q == '0)                   st_d = DONE;
            else if (we && (post_q == CNT_ONE)) st_d = DONE;
            else                                st_d = POST;
          end
        end

        POST: begin
          if (we) begin
            wp_d  = wp_q + WP_ONE;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == post_q - CNT_ONE) st_d = DONE;
          end
        end

        default: st_d = IDLE;
      endcase
    end
  end

  // State, pointers and registered decoder enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      wp_q    <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      trig_q  <= '0;
      start_q <= '0;
      cen_q   <= 1'b0;
      trdy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      start_q <= start_d;
      cen_q   <= (st_d == PRETRIG) || (st_d == ARMED) || (st_d == POST);
      trdy_q  <= (st_d == ARMED);
    end
  end

  // Output drive.
  always_comb begin
    bus.capture_en    = cen_q;
    bus.trigger_ready = trdy_q;
    bus.buf_we        = we;
    bus.buf_addr      = wp_q;
    trig_addr         = trig_q;
    start_addr        = start_q;
    busy              = active;
    done              = (st_q == DONE);
    state             = st_q;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one capture run of the logic-analyzer front end: after an arm request it fills a pre-trigger window, enables the trigger decoder, waits for its trigger pulse, then records a post-trigger window into the circular sample buffer. It drives the enable/ready pair of `Trigger_Decoder`, consumes its registered `trigger_start`, and generates buffer write strobes and addresses plus the readout pointers used by the upload logic.

## Interface
- `ADDR_W`, 10: sample-buffer address width; `DEPTH = 2**ADDR_W`.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `arm` in 1: single-cycle run request; honoured in IDLE and DONE only.
- `abort` in 1: single-cycle cancel; honoured in every state; priority over `arm`.
- `clear` in 1: single-cycle acknowledge; DONE -> IDLE.
- `pre_len` in ADDR_W+1: pre-trigger sample count; latched on accepted `arm`.
- `post_len` in ADDR_W+1: post-trigger sample count; latched on accepted `arm`.
- `sample_valid` in 1: one new sample is on the buffer data bus this cycle.
- `trigger_start` in 1: registered trigger pulse from `Trigger_Decoder`.
- `capture_en` out 1: to decoder `Capture_En`.
- `trigger_ready` out 1: to decoder `trigger_ready`.
- `buf_we` out 1: buffer write strobe.
- `buf_addr` out ADDR_W: buffer write address.
- `trig_addr` out ADDR_W: address of first post-trigger sample.
- `start_addr` out ADDR_W: address of oldest valid sample (`trig_addr - pre_len` mod DEPTH).
- `busy` out 1: high in PRETRIG, ARMED, POST.
- `done` out 1: high in DONE.
- `state` out 3: current state encoding, for status register.

## Operation
- States: IDLE, PRETRIG, ARMED, POST, DONE.
- IDLE/DONE + `arm`: latch lengths, write pointer `wp` <= 0, counter `cnt` <= 0; go PRETRIG, or ARMED if `pre_len == 0`.
- Write rule, PRETRIG/ARMED/POST: `buf_we = sample_valid` (combinational), `buf_addr = wp`; each write increments `wp` mod DEPTH (wraps DEPTH-1 -> 0).
- PRETRIG: each write increments `cnt`; the write with `cnt == pre_len-1` moves to ARMED.
- ARMED: writes continue circularly; `cnt` frozen. On `trigger_start`: `trig_addr` <= `wp`, `start_addr` <= `wp - pre_len` (ADDR_W bits, mod DEPTH). A write in the same cycle is the first post-trigger sample and loads `cnt` <= 1, otherwise `cnt` <= 0. Go POST, or DONE if `post_len == 0`. The same-cycle write still occurs when `post_len == 0`, but it is not counted.
- POST: each write increments `cnt`; the write with `cnt == post_len-1` moves to DONE. If the trigger-cycle write already satisfied `post_len == 1`, go directly to DONE.
- DONE: no writes, `capture_en` low, pointers held. `arm` starts a new run. `clear` returns to IDLE.
- `abort` from any state: next state IDLE, no write in the abort cycle, `trig_addr`/`start_addr` unchanged.
- `trigger_start` outside ARMED is ignored.
- `pre_len + post_len > DEPTH` is a configuration error and the result is unspecified. `pre_len` and `post_len` are each ≤ DEPTH.

## Timing
- Reset values: state IDLE; all outputs 0; `wp`, `cnt`, and latched lengths 0.
- `capture_en` is high exactly in PRETRIG, ARMED, POST.
- `trigger_ready` is high exactly in ARMED. Both are registered state decodes.
- Decoder latency is one clock: `trigger_ready` high in cycle n gives the earliest `trigger_start` in cycle n+1. The sequencer therefore reacts at most 2 cycles after the trigger-vector edge.
- `buf_we`/`buf_addr` are valid in the same cycle as `sample_valid`. The buffer is a synchronous-write RAM.
- `done` rises the cycle after the final post write.

## Structure
- Shared package `capture_pkg`: state enum (IDLE=0, PRETRIG=1, ARMED=2, POST=3, DONE=4) and `ADDR_W` default.
- Single module, no sub-modules.
- `wp` arithmetic is ADDR_W-bit with natural wrap; `cnt` is ADDR_W+1 bits so that DEPTH is reachable.

## Test plan
- Reset mid-POST: assert `rst_n=0` → all outputs 0 and state IDLE immediately (async), IDLE held after release.
- `pre_len=4`, `post_len=4`, continuous `sample_valid`, trigger at cycle 10 → writes to addresses 0..3 in PRETRIG, `trigger_ready` from 5th cycle; `trig_addr` is correct; exactly 4 post writes; `done` high; `start_addr = trig_addr-4`.
- `ADDR_W=4`, `pre_len=8`, trigger after 20 writes → `wp` wraps 15 → 0; `trig_addr=4`, `start_addr=12`.
- `pre_len=0`, `post_len=1` → ARMED the cycle after `arm`; trigger with a concurrent `sample_valid` gives one write, then DONE.
- `trigger_start` pulsed during PRETRIG and DONE → ignored, no state change.
- `abort` together with `arm` in DONE → IDLE, no write. `arm` then `clear` in DONE → new run, then IDLE after it completes.
